demux_1to3_5_buf: RTL and testbench
===================================

# demux_1to3_5_buf

Buffered 1-to-3 demultiplexer for 5-bit register-address/tag beats. It is the fan-out counterpart of the processor's 3-to-1 5-bit select path. It takes one valid/ready input stream with a 2-bit destination select and delivers each beat into one of three independent per-destination FIFOs, each with its own valid/ready output. Illegal selects are consumed, discarded and counted.

## Interface
- DEPTH, 2: entries per destination FIFO; power of two, ≥2
- CNT_W, 8: width of the illegal-select drop counter
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input beat present
- in_ready  out  1  input beat accepted this cycle when high with in_valid
- in_sel  in  2  destination: 0, 1, 2 legal; 3 illegal
- in_data  in  5  beat payload
- out_valid  out  3  bit k: destination k FIFO non-empty
- out_ready  in  3  bit k: consumer k takes head beat
- out_data0 / out_data1 / out_data2  out  5 each  head-of-FIFO payload per destination
- drop_cnt  out  CNT_W  saturating count of illegal-select beats
- drop_pulse  out  1  registered one-cycle pulse per dropped beat

## Operation
- Input transfer: in_valid & in_ready on a rising edge.
- in_ready = (in_sel==3) | !full[in_sel]. There is no pass-through on full: a full FIFO stays not-ready even if it pops in the same cycle.
- Legal transfer: in_data is pushed into FIFO[in_sel]. Other FIFOs are unaffected.
- Illegal transfer (sel 3): the beat is discarded. drop_pulse goes high the next cycle, and drop_cnt increments, saturating at 2^CNT_W−1.
- Output k transfer: out_valid[k] & out_ready[k]. The head beat is popped. out_data_k shows the next entry, or holds its last value when empty.
- Per FIFO: wr_ptr and rd_ptr of log2(DEPTH) bits wrap modulo DEPTH. count is log2(DEPTH)+1 bits. full = (count==DEPTH), empty = (count==0).
- Simultaneous push and pop on the same FIFO: count is unchanged and both pointers advance. This is legal when count ≥1. On a full FIFO, only the pop occurs because in_ready is low.
- Pops on different destinations in the same cycle are independent. All three may pop at once.
- out_ready[k] with out_valid[k] low has no effect.
- Ordering: per destination, strictly FIFO. There is no ordering guarantee across destinations.
- Reset mid-operation: all FIFO contents are discarded, regardless of pending handshakes that cycle.

## Timing
- Reset values: out_valid=3'b000, out_data0/1/2=5'd0, drop_cnt=0, drop_pulse=0, all pointers and counts 0. in_ready after reset = 1 for any in_sel.
- Latency: a beat accepted at edge N appears with out_valid at edge N (registered), i.e. visible in cycle N+1. It is poppable in that cycle.
- Minimum in→out turnaround is 1 cycle. Sustained throughput is 1 beat/cycle per destination when the consumer is always ready.
- in_ready is combinational from in_sel and registered full flags only. It never depends on out_ready, so there is no comb path out_ready→in_ready.
- out_valid and out_data are driven from registers/storage only, with no combinational path from inputs.
- drop_pulse: high exactly one cycle after each illegal transfer. Back-to-back illegal beats keep it high continuously.

## Structure
- Shared package/header: select codes SEL_D0=2'd0, SEL_D1=2'd1, SEL_D2=2'd2, SEL_BAD=2'd3, and the payload width constant 5.
- Sub-module fifo_sync_5 (parameter DEPTH): push/pop, full/empty/count, head data. It is instantiated three times.
- The top level holds the select decode, in_ready mux, and drop counter/pulse only.

## Test plan
- Reset then idle: out_valid=000, drop_cnt=0, and in_ready=1 for sel 0..3.
- Push 5'h11 sel0, 5'h12 sel1, 5'h13 sel2 on consecutive cycles with out_ready=000. Expected: out_valid=111 and out_data0/1/2 = 11/12/13. Then out_ready=111 for one cycle gives out_valid=000.
- DEPTH=2, out_ready=000, push 1, 2, 3 to sel1. Expected: third beat stalls with in_ready=0 at sel1. Driving sel0 in that cycle gives in_ready=1. Popping sel1 then lets beat 3 in, and the pop order is 1, 2, 3.
- Full FIFO with simultaneous pop and push request: the pop occurs, the push is refused that cycle and accepted the next. count goes 2→1→2.
- Four illegal beats back-to-back: in_ready=1 throughout, drop_pulse high for 4 cycles, drop_cnt=4, no out_valid. Separately, with CNT_W=2, five drops leave drop_cnt saturated at 3.
- Reset asserted while two FIFOs hold data and a push and pop are in flight: next cycle out_valid=000, all counts 0, drop_cnt=0.

Source files
------------

// File: rtl/demux_1to3_5_buf_pkg.sv
// demux_1to3_5_buf_pkg: select codes and payload width shared by the demux slice
package demux_1to3_5_buf_pkg;
  localparam int DATA_W = 5;
  typedef enum logic [1:0] {
    SEL_D0  = 2'd0,
    SEL_D1  = 2'd1,
    SEL_D2  = 2'd2,
    SEL_BAD = 2'd3
  } sel_e;
endpackage

// File: rtl/demux_1to3_5_buf_fifo_sync_5.sv
// fifo_sync_5: synchronous 5-bit FIFO whose head holds the last popped beat once empty
module fifo_sync_5
  import demux_1to3_5_buf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] rdata
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [DATA_W-1:0] hold;
  logic do_push, do_pop;
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? hold : mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      hold   <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        hold   <= mem[rd_ptr];
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/demux_1to3_5_buf.sv
// demux_1to3_5_buf: routes 5-bit beats into three per-destination FIFOs, counting illegal selects
module demux_1to3_5_buf
  import demux_1to3_5_buf_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_sel,
  input  logic [DATA_W-1:0] in_data,
  output logic [2:0]        out_valid,
  input  logic [2:0]        out_ready,
  output logic [DATA_W-1:0] out_data0,
  output logic [DATA_W-1:0] out_data1,
  output logic [DATA_W-1:0] out_data2,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              drop_pulse
);
  logic [2:0] full, empty;
  logic [DATA_W-1:0] head [3];
  logic drop;
  // ready looks only at registered full flags, never at out_ready
  assign in_ready  = in_sel == SEL_BAD || !full[in_sel];
  assign drop      = in_valid && in_sel == SEL_BAD;
  assign out_valid = ~empty;
  assign out_data0 = head[0];
  assign out_data1 = head[1];
  assign out_data2 = head[2];
  for (genvar k = 0; k < 3; k++) begin : g_fifo
    fifo_sync_5 #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_valid && in_sel == 2'(k)),
      .pop   (out_ready[k]),
      .wdata (in_data),
      .full  (full[k]),
      .empty (empty[k]),
      .rdata (head[k])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt   <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= drop;
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_demux_1to3_5_buf.sv
// tb_demux_1to3_5_buf: directed and random checks of the buffered demux against a queue model
module tb_demux_1to3_5_buf;
  localparam int DEPTH = 2;
  logic clk = 0, rst = 1, in_valid = 0;
  logic [1:0] in_sel = 0;
  logic [4:0] in_data = 0;
  logic [2:0] out_ready = 0;
  logic in_ready, drop_pulse, s_ready, s_pulse;
  logic [2:0] out_valid, s_valid;
  logic [4:0] out_data0, out_data1, out_data2, s_d0, s_d1, s_d2;
  logic [7:0] drop_cnt;
  logic [1:0] s_cnt;
  int n_cmp = 0, n_bad = 0;
  bit live = 0;
  typedef logic [4:0] q_t[$];
  q_t q [3];
  logic [4:0] last [3];
  int mcnt = 0, mcnt2 = 0;
  bit mpulse = 0;

  demux_1to3_5_buf #(.DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data0(out_data0),
    .out_data1(out_data1), .out_data2(out_data2), .drop_cnt(drop_cnt), .drop_pulse(drop_pulse));

  demux_1to3_5_buf #(.DEPTH(DEPTH), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_ready), .in_sel(in_sel),
    .in_data(in_data), .out_valid(s_valid), .out_ready(out_ready), .out_data0(s_d0),
    .out_data1(s_d1), .out_data2(s_d2), .drop_cnt(s_cnt), .drop_pulse(s_pulse));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [1:0] s, input logic [4:0] d, input logic [2:0] r);
    in_valid = v; in_sel = s; in_data = d; out_ready = r;
  endtask

  // reference: per-destination queues, pops seen before the same-edge push
  always @(posedge clk) begin
    bit acc;
    if (rst) begin
      for (int k = 0; k < 3; k++) begin q[k].delete(); last[k] = 0; end
      mcnt = 0; mcnt2 = 0; mpulse = 0;
    end else begin
      acc = in_valid && (in_sel == 3 || q[in_sel].size() < DEPTH);
      for (int k = 0; k < 3; k++)
        if (out_ready[k] && q[k].size() > 0) last[k] = q[k].pop_front();
      if (acc && in_sel != 3) q[in_sel].push_back(in_data);
      mpulse = acc && in_sel == 3;
      if (mpulse) begin
        if (mcnt < 255) mcnt++;
        if (mcnt2 < 3) mcnt2++;
      end
    end
  end

  always @(negedge clk) if (live) begin
    logic [2:0] mv;
    logic [4:0] md [3];
    for (int k = 0; k < 3; k++) begin
      mv[k] = q[k].size() > 0;
      md[k] = mv[k] ? q[k][0] : last[k];
    end
    chk("out_valid", out_valid, mv);
    chk("out_data0", out_data0, md[0]);
    chk("out_data1", out_data1, md[1]);
    chk("out_data2", out_data2, md[2]);
    chk("in_ready", in_ready, in_sel == 3 || q[in_sel].size() < DEPTH);
    chk("drop_cnt", drop_cnt, mcnt);
    chk("drop_pulse", drop_pulse, mpulse);
    chk("sat_drop_cnt", s_cnt, mcnt2);
  end

  initial begin
    drive(0, 0, 0, 0);
    tick();
    live = 1;
    tick();
    rst = 0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_data0", out_data0, 0);
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s); #1;
      chk("rst_in_ready", in_ready, 1);
    end
    drive(1, 0, 5'h11, 0); tick();
    drive(1, 1, 5'h12, 0); tick();
    drive(1, 2, 5'h13, 0); tick();
    drive(0, 0, 0, 0);
    chk("fan_valid", out_valid, 3'b111);
    chk("fan_d0", out_data0, 5'h11);
    chk("fan_d1", out_data1, 5'h12);
    chk("fan_d2", out_data2, 5'h13);
    out_ready = 3'b111; tick(); out_ready = 0;
    chk("fan_drain", out_valid, 0);
    chk("fan_hold0", out_data0, 5'h11);
    drive(1, 1, 5'd1, 0); tick();
    in_data = 5'd2; tick();
    in_data = 5'd3; #1;
    chk("full_stall", in_ready, 0);
    in_sel = 0; #1;
    chk("other_ready", in_ready, 1);
    in_sel = 1;
    chk("order_1", out_data1, 1);
    out_ready = 3'b010; tick();
    chk("order_2", out_data1, 2);
    chk("ready_after_pop", in_ready, 1);
    out_ready = 0; tick();
    in_valid = 0;
    chk("refull", in_ready, 0);
    out_ready = 3'b010; tick();
    chk("order_3", out_data1, 3);
    tick();
    out_ready = 0;
    chk("drained1", out_valid, 0);
    chk("hold1", out_data1, 3);
    for (int i = 0; i < 4; i++) begin
      drive(1, 3, 5'($urandom), 0); #1;
      chk("bad_ready", in_ready, 1);
      tick();
      chk("bad_pulse", drop_pulse, 1);
    end
    in_valid = 0;
    chk("bad_cnt4", drop_cnt, 4);
    chk("bad_no_valid", out_valid, 0);
    tick();
    chk("pulse_off", drop_pulse, 0);
    drive(1, 3, 0, 0); tick();
    in_valid = 0;
    chk("sat_cnt", s_cnt, 3);
    chk("cnt5", drop_cnt, 5);
    drive(1, 0, 5'h0a, 0); tick();
    drive(1, 2, 5'h0b, 0); tick();
    drive(1, 1, 5'h0c, 3'b001); rst = 1; tick();
    rst = 0; drive(0, 0, 0, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_cnt", drop_cnt, 0);
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, 2'($urandom), 5'($urandom), 3'($urandom));
      rst = $urandom_range(0, 199) == 0;
      tick();
    end
    rst = 0; drive(0, 0, 0, 0);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
